// File: rtl/core_inst_sequencer.sv
// Sequences one weight-stationary tile on the core: kernel xmem->L0, L0->PE weight load,
// activation xmem->L0, execute, then OFIFO drain into pmem, emitting a registered 35-bit inst word.
module core_inst_sequencer #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] k_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic [ADDR_W-1:0] a_len,
    input  logic              relu_en,
    input  logic              acc_en,
    input  logic              ofifo_valid,
    output logic [34:0]       inst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = ADDR_W + $clog2(ROW + COL + 1) + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [34:0] IDLE_INST = (35'd1 << 32) | (35'd1 << 31) | (35'd1 << 19) | (35'd1 << 18);

    localparam logic [CNT_W-1:0] COL_C     = CNT_W'(COL);
    localparam logic [CNT_W-1:0] RC_LAST_C = CNT_W'(ROW + COL - 1);
    localparam logic [WD_W-1:0]  TIMEOUT_C = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_KFEED,
        S_ALOAD,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [34:0]        inst_q, inst_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  kBase_q, kBase_d;
    logic [ADDR_W-1:0]  aBase_q, aBase_d;
    logic [ADDR_W-1:0]  pBase_q, pBase_d;
    logic [ADDR_W-1:0]  aLen_q, aLen_d;
    logic               relu_q, relu_d;
    logic               acc_q, acc_d;
    logic [ADDR_W-1:0]  rdCnt_q, rdCnt_d;
    logic [ADDR_W-1:0]  wrCnt_q, wrCnt_d;
    logic               pend_q, pend_d;
    logic [WD_W-1:0]    wdCnt_q, wdCnt_d;
    logic               error_q, error_d;
    logic               zeroDone_q, zeroDone_d;
    logic [CNT_W-1:0]   aLenExt;

    assign aLenExt = CNT_W'(aLen_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            inst_q     <= IDLE_INST;
            cnt_q      <= '0;
            kBase_q    <= '0;
            aBase_q    <= '0;
            pBase_q    <= '0;
            aLen_q     <= '0;
            relu_q     <= 1'b0;
            acc_q      <= 1'b0;
            rdCnt_q    <= '0;
            wrCnt_q    <= '0;
            pend_q     <= 1'b0;
            wdCnt_q    <= '0;
            error_q    <= 1'b0;
            zeroDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            cnt_q      <= cnt_d;
            kBase_q    <= kBase_d;
            aBase_q    <= aBase_d;
            pBase_q    <= pBase_d;
            aLen_q     <= aLen_d;
            relu_q     <= relu_d;
            acc_q      <= acc_d;
            rdCnt_q    <= rdCnt_d;
            wrCnt_q    <= wrCnt_d;
            pend_q     <= pend_d;
            wdCnt_q    <= wdCnt_d;
            error_q    <= error_d;
            zeroDone_q <= zeroDone_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        inst_d     = IDLE_INST;
        cnt_d      = cnt_q + CNT_W'(1);
        kBase_d    = kBase_q;
        aBase_d    = aBase_q;
        pBase_d    = pBase_q;
        aLen_d     = aLen_q;
        relu_d     = relu_q;
        acc_d      = acc_q;
        rdCnt_d    = rdCnt_q;
        wrCnt_d    = wrCnt_q;
        pend_d     = 1'b0;
        wdCnt_d    = wdCnt_q;
        error_d    = error_q;
        zeroDone_d = 1'b0;

        if (state_q != S_IDLE && state_q != S_DONE) begin
            inst_d[34] = relu_q;
            inst_d[33] = acc_q;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && !abort) begin
                    kBase_d = k_base;
                    aBase_d = a_base;
                    pBase_d = p_base;
                    aLen_d  = a_len;
                    relu_d  = relu_en;
                    acc_d   = acc_en;
                    rdCnt_d = '0;
                    wrCnt_d = '0;
                    wdCnt_d = '0;
                    error_d = 1'b0;
                    if (a_len == '0) begin
                        zeroDone_d = 1'b1;
                    end else begin
                        state_d = S_KLOAD;
                    end
                end
            end

            // L0 write trails the xmem read by one cycle because the SRAM Q is registered.
            S_KLOAD: begin
                if (cnt_q < COL_C) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = kBase_q + cnt_q[ADDR_W-1:0];
                end
                if (cnt_q != '0) begin
                    inst_d[2] = 1'b1;
                end
                if (cnt_q == COL_C) begin
                    state_d = S_KFEED;
                    cnt_d   = '0;
                end
            end

            S_KFEED: begin
                inst_d[0] = 1'b1;
                if (cnt_q < COL_C) begin
                    inst_d[3] = 1'b1;
                end
                if (cnt_q == RC_LAST_C) begin
                    state_d = S_ALOAD;
                    cnt_d   = '0;
                end
            end

            S_ALOAD: begin
                if (cnt_q < aLenExt) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = aBase_q + cnt_q[ADDR_W-1:0];
                end
                if (cnt_q != '0) begin
                    inst_d[2] = 1'b1;
                end
                if (cnt_q == aLenExt) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end
            end

            S_EXEC: begin
                inst_d[1] = 1'b1;
                if (cnt_q < aLenExt) begin
                    inst_d[3] = 1'b1;
                end
                if (cnt_q == aLenExt + RC_LAST_C) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end

            // Each OFIFO read is followed one cycle later by its pmem write.
            S_DRAIN: begin
                cnt_d = '0;
                if (pend_q) begin
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = pBase_q + wrCnt_q;
                    wrCnt_d       = wrCnt_q + ADDR_W'(1);
                end
                if (ofifo_valid && rdCnt_q != aLen_q) begin
                    inst_d[6] = 1'b1;
                    rdCnt_d   = rdCnt_q + ADDR_W'(1);
                    pend_d    = 1'b1;
                end
                wdCnt_d = ofifo_valid ? '0 : wdCnt_q + WD_W'(1);
                if (pend_q && wrCnt_d == aLen_q) begin
                    state_d = S_DONE;
                end else if (!ofifo_valid && wdCnt_d == TIMEOUT_C) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort beats every transition, including a start in IDLE; the error flag survives it.
        if (abort) begin
            state_d    = S_IDLE;
            inst_d     = IDLE_INST;
            cnt_d      = '0;
            pend_d     = 1'b0;
            rdCnt_d    = '0;
            wrCnt_d    = '0;
            wdCnt_d    = '0;
            zeroDone_d = 1'b0;
        end
    end

    assign inst  = inst_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE) || zeroDone_q;
    assign error = error_q;

endmodule
